// File: rtl/alu_resp_unit.sv
// alu_resp_unit: handshaked ALU responder. Each accepted request is computed
// combinationally, and its full result is pushed into an in-order queue of
// DEPTH entries. The queue head is presented on the rsp_* port. The unit also
// keeps sticky flags and a running count of accepted operations.
module alu_resp_unit #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 2,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [WIDTH-1:0] req_a,
    input  logic [WIDTH-1:0] req_b,
    input  logic [1:0]       req_sel,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_y,
    output logic [WIDTH:0]   rsp_full,
    output logic             rsp_zero,
    output logic             rsp_neg,
    output logic             rsp_carry,
    output logic             sticky_zero,
    output logic             sticky_neg,
    output logic             sticky_carry,
    input  logic             clr_sticky,
    output logic [CNT_W-1:0] op_count
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CQ_W  = $clog2(DEPTH + 1);

    // Full WIDTH+1 bit result. Subtraction is a + ~b + 1, so the carry-out
    // means "no borrow". Logic ops never produce a carry.
    function automatic logic [WIDTH:0] alu_full(input logic [WIDTH-1:0] a,
                                                input logic [WIDTH-1:0] b,
                                                input logic [1:0]       sel);
        logic [WIDTH:0] one;
        one = {{WIDTH{1'b0}}, 1'b1};
        case (sel)
            2'b00:   alu_full = {1'b0, a} + {1'b0, b};
            2'b01:   alu_full = {1'b0, a} + {1'b0, ~b} + one;
            2'b10:   alu_full = {1'b0, a & b};
            default: alu_full = {1'b0, a | b};
        endcase
    endfunction

    // Flags derived from a full result, packed as {zero, neg, carry}.
    function automatic logic [2:0] alu_flags(input logic [WIDTH:0] full);
        alu_flags = {(full[WIDTH-1:0] == '0), full[WIDTH-1], full[WIDTH]};
    endfunction

    // ---- stage p0: combinational compute on the request port ----
    logic [WIDTH:0] full_p0;
    logic [2:0]     flags_p0;
    logic           acc_p0;
    logic           pop_p1;

    assign full_p0  = alu_full(req_a, req_b, req_sel);
    assign flags_p0 = alu_flags(full_p0);
    assign acc_p0   = req_valid && req_ready;

    // ---- stage p1: result queue and status registers ----
    logic [WIDTH:0]   q_full_p1 [DEPTH];
    logic [PTR_W-1:0] wr_ptr_p1;
    logic [PTR_W-1:0] rd_ptr_p1;
    logic [CQ_W-1:0]  count_p1;
    logic [WIDTH:0]   last_full_p1;

    assign pop_p1    = rsp_valid && rsp_ready;
    assign rsp_valid = (count_p1 != '0);
    assign req_ready = (count_p1 != CQ_W'(DEPTH));

    // Queue storage is data only; it needs no reset because count gates it.
    always_ff @(posedge clk) begin
        if (acc_p0) q_full_p1[wr_ptr_p1] <= full_p0;
    end

    // Pointers, occupancy and the held-last-result register.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_p1    <= '0;
            rd_ptr_p1    <= '0;
            count_p1     <= '0;
            last_full_p1 <= '0;
        end else begin
            if (acc_p0) wr_ptr_p1 <= wr_ptr_p1 + PTR_W'(1);
            if (pop_p1) begin
                rd_ptr_p1    <= rd_ptr_p1 + PTR_W'(1);
                last_full_p1 <= q_full_p1[rd_ptr_p1];
            end
            case ({acc_p0, pop_p1})
                2'b10:   count_p1 <= count_p1 + CQ_W'(1);
                2'b01:   count_p1 <= count_p1 - CQ_W'(1);
                default: count_p1 <= count_p1;
            endcase
        end
    end

    // Sticky flags: a clear applies before OR-ing in a same-edge accept.
    always_ff @(posedge clk) begin
        if (rst) begin
            {sticky_zero, sticky_neg, sticky_carry} <= 3'b000;
        end else if (acc_p0) begin
            {sticky_zero, sticky_neg, sticky_carry} <=
                (clr_sticky ? 3'b000 : {sticky_zero, sticky_neg, sticky_carry}) | flags_p0;
        end else if (clr_sticky) begin
            {sticky_zero, sticky_neg, sticky_carry} <= 3'b000;
        end
    end

    // Accepted-operation counter, wraps naturally.
    always_ff @(posedge clk) begin
        if (rst)         op_count <= '0;
        else if (acc_p0) op_count <= op_count + CNT_W'(1);
    end

    // Head of queue while non-empty, otherwise the last delivered result.
    assign rsp_full  = rsp_valid ? q_full_p1[rd_ptr_p1] : last_full_p1;
    assign rsp_y     = rsp_full[WIDTH-1:0];
    assign rsp_zero  = (rsp_y == '0);
    assign rsp_neg   = rsp_y[WIDTH-1];
    assign rsp_carry = rsp_full[WIDTH];

endmodule

// File: tb/tb_alu_resp_unit.sv
// Self-checking bench for alu_resp_unit with a scoreboard queue.
module tb_alu_resp_unit;

    localparam int W  = 4;
    localparam int D  = 2;
    localparam int CW = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          req_valid, req_ready;
    logic [W-1:0]  req_a, req_b;
    logic [1:0]    req_sel;
    logic          rsp_valid, rsp_ready;
    logic [W-1:0]  rsp_y;
    logic [W:0]    rsp_full;
    logic          rsp_zero, rsp_neg, rsp_carry;
    logic          sticky_zero, sticky_neg, sticky_carry;
    logic          clr_sticky;
    logic [CW-1:0] op_count;

    always #5 clk = ~clk;

    alu_resp_unit #(.WIDTH(W), .DEPTH(D), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .req_sel(req_sel),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_y(rsp_y), .rsp_full(rsp_full),
        .rsp_zero(rsp_zero), .rsp_neg(rsp_neg), .rsp_carry(rsp_carry),
        .sticky_zero(sticky_zero), .sticky_neg(sticky_neg), .sticky_carry(sticky_carry),
        .clr_sticky(clr_sticky), .op_count(op_count)
    );

    logic [W:0]    exp_q[$];
    logic [CW-1:0] exp_cnt = '0;
    int            n_chk  = 0;
    int            n_pass = 0;
    int            n_fail = 0;
    int            n_rsp  = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: integer arithmetic, subtraction as a - b + 2^W mod 2^(W+1).
    function automatic logic [W:0] ref_full(input int a, input int b, input int sel);
        int r;
        case (sel)
            0:       r = a + b;
            1:       r = a - b + 16;
            2:       r = a & b;
            default: r = a | b;
        endcase
        return r[W:0];
    endfunction

    // Scoreboard: observe handshakes mid-cycle, before the edge that takes them.
    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
            exp_cnt = '0;
        end else begin
            if (rsp_valid && rsp_ready) begin
                if (exp_q.size() == 0) begin
                    check("rsp_with_empty_model", 32'(rsp_valid), 32'd0);
                end else begin
                    logic [W:0] e;
                    e = exp_q.pop_front();
                    n_rsp++;
                    check("rsp_full",  32'(rsp_full),  32'(e));
                    check("rsp_y",     32'(rsp_y),     32'(e[W-1:0]));
                    check("rsp_zero",  32'(rsp_zero),  32'(e[W-1:0] == 0));
                    check("rsp_neg",   32'(rsp_neg),   32'(e[W-1]));
                    check("rsp_carry", 32'(rsp_carry), 32'(e[W]));
                end
            end
            if (req_valid && req_ready) begin
                exp_q.push_back(ref_full(int'(req_a), int'(req_b), int'(req_sel)));
                exp_cnt = exp_cnt + 1'b1;
            end
        end
    end

    // Present one request and hold it until it is accepted (bounded).
    task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic [1:0] sel);
        bit ok;
        int t;
        req_a = a; req_b = b; req_sel = sel; req_valid = 1'b1;
        t = 0;
        do begin
            @(negedge clk); ok = req_ready;
            @(posedge clk); #1; t++;
        end while (!ok && t < 50);
        if (!ok) check("send_timeout", 32'(ok), 32'd1);
        req_valid = 1'b0;
    endtask

    // Drain everything queued (bounded); the scoreboard checks each pop.
    task automatic drain();
        int t;
        rsp_ready = 1'b1;
        t = 0;
        @(negedge clk);
        while (rsp_valid && t < 50) begin
            @(negedge clk); t++;
        end
        check("drain_empty", 32'(rsp_valid), 32'd0);
        check("drain_model_empty", 32'(exp_q.size()), 32'd0);
        @(posedge clk); #1;
    endtask

    initial begin
        logic [W:0] head;
        int         base;
        logic [CW-1:0] start_cnt;

        rst = 1'b1; req_valid = 1'b0; req_a = '0; req_b = '0; req_sel = '0;
        rsp_ready = 1'b0; clr_sticky = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // Reset then idle.
        @(negedge clk);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_req_ready", 32'(req_ready), 32'd1);
        check("rst_op_count",  32'(op_count),  32'd0);
        check("rst_sticky",    32'({sticky_zero, sticky_neg, sticky_carry}), 32'd0);
        check("rst_rsp_full",  32'(rsp_full),  32'd0);
        @(posedge clk); #1;

        // Add wrap: 1111 + 0001.
        send(4'hF, 4'h1, 2'b00);
        @(negedge clk);
        check("add_latency_valid", 32'(rsp_valid), 32'd1);
        check("add_y",     32'(rsp_y),     32'h0);
        check("add_full",  32'(rsp_full),  32'h10);
        check("add_zero",  32'(rsp_zero),  32'd1);
        check("add_neg",   32'(rsp_neg),   32'd0);
        check("add_carry", 32'(rsp_carry), 32'd1);
        check("add_sticky", 32'({sticky_zero, sticky_neg, sticky_carry}), 32'b101);
        check("add_op_count", 32'(op_count), 32'd1);
        @(posedge clk); #1;
        drain();
        check("rsp_hold_after_empty", 32'(rsp_full), 32'h10);

        // Sub with borrow, then and / or, delivered in order.
        rsp_ready = 1'b0;
        send(4'h3, 4'h5, 2'b01);
        @(negedge clk);
        check("sub_y",     32'(rsp_y),     32'hE);
        check("sub_full",  32'(rsp_full),  32'h0E);
        check("sub_neg",   32'(rsp_neg),   32'd1);
        check("sub_carry", 32'(rsp_carry), 32'd0);
        @(posedge clk); #1;
        send(4'hC, 4'hA, 2'b10);
        drain();
        check("and_last_y", 32'(rsp_y), 32'h8);
        send(4'hC, 4'hA, 2'b11);
        drain();
        check("or_last_y", 32'(rsp_y), 32'hE);

        // Backpressure: three back-to-back requests with the consumer stalled.
        rsp_ready = 1'b0;
        req_valid = 1'b1; req_a = 4'h2; req_b = 4'h3; req_sel = 2'b00;
        @(posedge clk); #1;
        req_a = 4'h9; req_b = 4'h4; req_sel = 2'b01;
        @(negedge clk);
        check("bp_ready_second", 32'(req_ready), 32'd1);
        @(posedge clk); #1;
        req_a = 4'h6; req_b = 4'h3; req_sel = 2'b11;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("bp_ready_full", 32'(req_ready), 32'd0);
            check("bp_head_stable", 32'(rsp_full), 32'h05);
            @(posedge clk); #1;
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        check("bp_ready_before_pop", 32'(req_ready), 32'd0);
        @(posedge clk); #1;
        @(negedge clk);
        check("bp_ready_after_pop", 32'(req_ready), 32'd1);
        @(posedge clk); #1;
        req_valid = 1'b0;
        drain();
        check("bp_op_count", 32'(op_count), 32'(exp_cnt));

        // Full throughput: accept and deliver on every cycle.
        rsp_ready = 1'b1;
        base = n_rsp;
        req_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            req_a = W'($urandom_range(0, 15));
            req_b = W'($urandom_range(0, 15));
            req_sel = 2'($urandom_range(0, 3));
            @(negedge clk);
            check("tp_ready", 32'(req_ready), 32'd1);
            if (i > 0) check("tp_no_bubble", 32'(rsp_valid), 32'd1);
            @(posedge clk); #1;
        end
        req_valid = 1'b0;
        @(negedge clk);
        check("tp_last_valid", 32'(rsp_valid), 32'd1);
        @(posedge clk); #1;
        drain();
        check("tp_count", 32'(n_rsp - base), 32'd10);

        // Sticky clear colliding with accepts.
        send(4'h3, 4'h5, 2'b01);
        @(negedge clk);
        check("sticky_neg_set", 32'(sticky_neg), 32'd1);
        @(posedge clk); #1;
        clr_sticky = 1'b1;
        send(4'h1, 4'h1, 2'b00);
        clr_sticky = 1'b0;
        @(negedge clk);
        check("clr_add_sticky", 32'({sticky_zero, sticky_neg, sticky_carry}), 32'b000);
        @(posedge clk); #1;
        send(4'h3, 4'h5, 2'b01);
        clr_sticky = 1'b1;
        send(4'hF, 4'h1, 2'b00);
        clr_sticky = 1'b0;
        @(negedge clk);
        check("clr_wrap_sticky", 32'({sticky_zero, sticky_neg, sticky_carry}), 32'b101);
        @(posedge clk); #1;
        clr_sticky = 1'b1;
        @(posedge clk); #1;
        clr_sticky = 1'b0;
        @(negedge clk);
        check("clr_alone_sticky", 32'({sticky_zero, sticky_neg, sticky_carry}), 32'b000);
        @(posedge clk); #1;
        drain();

        // 256 accepts wrap op_count to where it started.
        start_cnt = exp_cnt;
        req_valid = 1'b1;
        for (int i = 0; i < 256; i++) begin
            req_a = W'(i); req_b = W'(i >> 4); req_sel = 2'(i);
            @(posedge clk); #1;
        end
        req_valid = 1'b0;
        drain();
        check("wrap_op_count", 32'(op_count), 32'(start_cnt));
        check("wrap_model_count", 32'(exp_cnt), 32'(start_cnt));

        // Reset with two entries queued discards them.
        rsp_ready = 1'b0;
        send(4'h7, 4'h1, 2'b00);
        send(4'h8, 4'h2, 2'b01);
        @(negedge clk);
        check("pre_rst_ready", 32'(req_ready), 32'd0);
        @(posedge clk); #1;
        rst = 1'b1; req_valid = 1'b1; rsp_ready = 1'b1; clr_sticky = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0; req_valid = 1'b0; rsp_ready = 1'b0;
        @(negedge clk);
        check("mid_rst_valid",  32'(rsp_valid), 32'd0);
        check("mid_rst_ready",  32'(req_ready), 32'd1);
        check("mid_rst_full",   32'(rsp_full),  32'd0);
        check("mid_rst_count",  32'(op_count),  32'd0);
        check("mid_rst_sticky", 32'({sticky_zero, sticky_neg, sticky_carry}), 32'b000);
        @(posedge clk); #1;
        send(4'h5, 4'h5, 2'b01);
        @(negedge clk);
        head = rsp_full;
        check("post_rst_head", 32'(head), 32'h10);
        @(posedge clk); #1;
        drain();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
